// File: rtl/mem_sqn_allocator_pkg.sv
// Shared constants and types for the load/store sequence-number allocator.
package mem_sqn_allocator_pkg;

  localparam int SQN_W       = 6;
  localparam int NUM_UOPS    = 2;
  localparam int BR_W        = 52;

  // Branch-bus field positions
  localparam int BR_VALID    = 51;
  localparam int BR_STSQN_HI = 12;
  localparam int BR_STSQN_LO = BR_STSQN_HI - SQN_W + 1;
  localparam int BR_LDSQN_HI = 6;
  localparam int BR_LDSQN_LO = BR_LDSQN_HI - SQN_W + 1;
  localparam int BR_FLUSH    = 0;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } alloc_state_t;

endpackage : mem_sqn_allocator_pkg

// File: rtl/mem_sqn_allocator_prefix_count.sv
// Exclusive prefix count of a slot mask: prefix_o[k] = number of set bits
// below slot k, total_o = number of set bits overall.
module sqn_prefix_count #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         mask_i,
  output logic [N-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]        total_o
);

  // Ripple a running count across the slots, oldest first
  always_comb begin
    logic [CW-1:0] run;
    // NOTE: every variable assigned here gets a default up front so no
    // path leaves it unassigned, which would infer a latch.
    run      = '0;
    prefix_o = '0;
    for (int k = 0; k < N; k++) begin
      prefix_o[k] = run;
      run         = run + CW'(mask_i[k]);
    end
    total_o = run;
  end

endmodule : sqn_prefix_count

// File: rtl/mem_sqn_allocator.sv
// Rename-stage allocator: stamps dispatched uops with load/store sequence
// numbers, stalls when the load buffer or store queue would overflow, and
// rewinds on branch recovery with one dead recovery cycle.
module mem_sqn_allocator
  import mem_sqn_allocator_pkg::*;
#(
  parameter int NUM_UOPS_P = NUM_UOPS,
  parameter int SQN_W_P    = SQN_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_UOPS_P-1:0]         IN_valid,
  input  logic [NUM_UOPS_P-1:0]         IN_isLoad,
  input  logic [NUM_UOPS_P-1:0]         IN_isStore,
  input  logic [SQN_W_P-1:0]            IN_maxLoadSqN,
  input  logic [SQN_W_P-1:0]            IN_maxStoreSqN,
  input  logic [BR_W-1:0]               IN_branch,
  output logic [NUM_UOPS_P-1:0]         OUT_valid,
  output logic [NUM_UOPS_P*SQN_W_P-1:0] OUT_loadSqN,
  output logic [NUM_UOPS_P*SQN_W_P-1:0] OUT_storeSqN,
  output logic                          OUT_stall
);

  localparam int CW = $clog2(NUM_UOPS_P + 1);

  alloc_state_t                          state_q;
  logic                                  init_q;
  logic [SQN_W_P-1:0]                    next_load_q, next_store_q;
  logic [NUM_UOPS_P-1:0]                 out_valid_q;
  logic [NUM_UOPS_P-1:0][SQN_W_P-1:0]    out_ld_q, out_st_q;

  logic [NUM_UOPS_P-1:0]                 ld_mask, st_mask;
  logic [NUM_UOPS_P-1:0][CW-1:0]         ld_prefix, st_prefix;
  logic [CW-1:0]                         ld_total, st_total;
  logic [NUM_UOPS_P-1:0][SQN_W_P-1:0]    ld_sqn, st_sqn;
  logic                                  cap_stall;
  logic                                  br_valid, br_flush;
  logic                                  grant;

  // Bits of the branch bus this block does not consume
  logic unused_branch_bits;
  assign unused_branch_bits = ^IN_branch[BR_VALID-1:BR_STSQN_HI+1];

  assign br_valid = IN_branch[BR_VALID];
  assign br_flush = IN_branch[BR_FLUSH];

  // Only valid slots occupy a sequence number
  assign ld_mask = IN_valid & IN_isLoad;
  assign st_mask = IN_valid & IN_isStore;

  sqn_prefix_count #(.N(NUM_UOPS_P), .CW(CW)) u_ld_count (
    .mask_i   (ld_mask),
    .prefix_o (ld_prefix),
    .total_o  (ld_total)
  );

  sqn_prefix_count #(.N(NUM_UOPS_P), .CW(CW)) u_st_count (
    .mask_i   (st_mask),
    .prefix_o (st_prefix),
    .total_o  (st_total)
  );

  // Per-slot numbering and capacity check; a positive wrapped difference
  // (non-zero with clear sign bit) means the slot passes the published max
  always_comb begin
    logic [SQN_W_P-1:0] d_ld, d_st;
    ld_sqn    = '0;
    st_sqn    = '0;
    cap_stall = 1'b0;
    d_ld      = '0;
    d_st      = '0;
    for (int k = 0; k < NUM_UOPS_P; k++) begin
      ld_sqn[k] = next_load_q  + SQN_W_P'(ld_prefix[k]);
      st_sqn[k] = next_store_q + SQN_W_P'(st_prefix[k]);
      d_ld      = ld_sqn[k] - IN_maxLoadSqN;
      d_st      = st_sqn[k] - IN_maxStoreSqN;
      if (ld_mask[k] && (d_ld != '0) && !d_ld[SQN_W_P-1]) cap_stall = 1'b1;
      if (st_mask[k] && (d_st != '0) && !d_st[SQN_W_P-1]) cap_stall = 1'b1;
    end
  end

  assign OUT_stall = rst | init_q | br_valid | (state_q == RECOVER) | cap_stall;
  assign grant     = ~OUT_stall;

  // Allocator FSM, counters and registered dispatch outputs
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= RUN;
      init_q       <= 1'b1;
      next_load_q  <= '0;
      next_store_q <= '0;
      out_valid_q  <= '0;
      out_ld_q     <= '0;
      out_st_q     <= '0;
    end else begin
      init_q <= 1'b0;
      if (br_valid) begin
        state_q     <= RECOVER;
        out_valid_q <= '0;
        if (br_flush) begin
          next_load_q  <= IN_branch[BR_LDSQN_HI:BR_LDSQN_LO];
          next_store_q <= IN_branch[BR_STSQN_HI:BR_STSQN_LO];
        end
      end else if (state_q == RECOVER) begin
        state_q     <= RUN;
        out_valid_q <= '0;
      end else if (grant) begin
        out_valid_q  <= IN_valid;
        out_ld_q     <= ld_sqn;
        out_st_q     <= st_sqn;
        next_load_q  <= next_load_q  + SQN_W_P'(ld_total);
        next_store_q <= next_store_q + SQN_W_P'(st_total);
      end else begin
        out_valid_q <= '0;
      end
    end
  end

  assign OUT_valid    = out_valid_q;
  assign OUT_loadSqN  = out_ld_q;
  assign OUT_storeSqN = out_st_q;

endmodule : mem_sqn_allocator

// File: tb/tb_mem_sqn_allocator.sv
// Directed, table-driven bench for the load/store sequence-number allocator.
module tb_mem_sqn_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  IN_valid, IN_isLoad, IN_isStore;
  logic [5:0]  IN_maxLoadSqN, IN_maxStoreSqN;
  logic [51:0] IN_branch;
  logic [1:0]  OUT_valid;
  logic [11:0] OUT_loadSqN, OUT_storeSqN;
  logic        OUT_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_sqn_allocator dut (
    .clk            (clk),
    .rst            (rst),
    .IN_valid       (IN_valid),
    .IN_isLoad      (IN_isLoad),
    .IN_isStore     (IN_isStore),
    .IN_maxLoadSqN  (IN_maxLoadSqN),
    .IN_maxStoreSqN (IN_maxStoreSqN),
    .IN_branch      (IN_branch),
    .OUT_valid      (OUT_valid),
    .OUT_loadSqN    (OUT_loadSqN),
    .OUT_storeSqN   (OUT_storeSqN),
    .OUT_stall      (OUT_stall)
  );

  typedef struct {
    logic [1:0] v, isl, iss;
    logic [5:0] maxl, maxs;
    logic       br, fl;
    logic [5:0] bld, bst;
    logic       xstall;
    logic [1:0] xov;
    logic [5:0] xl0, xl1, xs0, xs1;
    logic       chk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int v, int isl, int iss, int maxl, int maxs,
                              int br, int fl, int bld, int bst,
                              int xstall, int xov, int xl0, int xl1,
                              int xs0, int xs1, int chk);
    vec_t r;
    r.v = 2'(v);       r.isl = 2'(isl);   r.iss = 2'(iss);
    r.maxl = 6'(maxl); r.maxs = 6'(maxs);
    r.br = 1'(br);     r.fl = 1'(fl);
    r.bld = 6'(bld);   r.bst = 6'(bst);
    r.xstall = 1'(xstall); r.xov = 2'(xov);
    r.xl0 = 6'(xl0);   r.xl1 = 6'(xl1);
    r.xs0 = 6'(xs0);   r.xs1 = 6'(xs1);
    r.chk = 1'(chk);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    IN_valid       = t.v;
    IN_isLoad      = t.isl;
    IN_isStore     = t.iss;
    IN_maxLoadSqN  = t.maxl;
    IN_maxStoreSqN = t.maxs;
    IN_branch      = '0;
    IN_branch[51]  = t.br;
    IN_branch[12:7] = t.bst;
    IN_branch[6:1] = t.bld;
    IN_branch[0]   = t.fl;
  endtask

  // Drive one vector after a rising edge, check the combinational stall,
  // then check the registered outputs just after the next rising edge
  task automatic apply(input vec_t t, input int idx);
    drive(t);
    #1;
    check($sformatf("v%0d stall", idx), 32'(OUT_stall), 32'(t.xstall));
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), 32'(OUT_valid), 32'(t.xov));
    if (t.chk) begin
      check($sformatf("v%0d ld0", idx), 32'(OUT_loadSqN[5:0]),   32'(t.xl0));
      check($sformatf("v%0d ld1", idx), 32'(OUT_loadSqN[11:6]),  32'(t.xl1));
      check($sformatf("v%0d st0", idx), 32'(OUT_storeSqN[5:0]),  32'(t.xs0));
      check($sformatf("v%0d st1", idx), 32'(OUT_storeSqN[11:6]), 32'(t.xs1));
    end
  endtask

  initial begin
    //        v isl iss maxl maxs br fl bld bst  stall ov  l0 l1 s0 s1 chk
    vecs.push_back(mk(3, 3, 0,  7, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v0  first cycle after reset
    vecs.push_back(mk(3, 3, 0,  7, 20, 0, 0,  0,  0,  0, 3,  0, 1, 0, 0, 1)); // v1
    vecs.push_back(mk(3, 3, 0,  7, 20, 0, 0,  0,  0,  0, 3,  2, 3, 0, 0, 1)); // v2
    vecs.push_back(mk(3, 3, 0,  7, 20, 0, 0,  0,  0,  0, 3,  4, 5, 0, 0, 1)); // v3
    vecs.push_back(mk(1, 1, 0,  7, 20, 0, 0,  0,  0,  0, 1,  6, 7, 0, 0, 1)); // v4
    vecs.push_back(mk(3, 3, 0,  7, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v5  7,8 > 7
    vecs.push_back(mk(1, 1, 0,  7, 20, 0, 0,  0,  0,  0, 1,  7, 8, 0, 0, 1)); // v6  equality ok
    vecs.push_back(mk(0, 0, 0,  7, 20, 0, 0,  0,  0,  0, 0,  0, 0, 0, 0, 0)); // v7  idle
    vecs.push_back(mk(0, 0, 0,  7, 20, 1, 1,  9,  5,  1, 0,  0, 0, 0, 0, 0)); // v8  flush ld9 st5
    vecs.push_back(mk(3, 2, 1, 20, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v9  recover
    vecs.push_back(mk(3, 2, 1, 20, 20, 0, 0,  0,  0,  0, 3,  9, 9, 5, 6, 1)); // v10
    vecs.push_back(mk(3, 0, 3, 20, 20, 0, 0,  0,  0,  0, 3, 10,10, 6, 7, 1)); // v11
    vecs.push_back(mk(0, 0, 0, 20, 20, 1, 1, 63,  8,  1, 0,  0, 0, 0, 0, 0)); // v12 flush ld63 st8
    vecs.push_back(mk(0, 0, 0, 20, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v13 recover
    vecs.push_back(mk(3, 3, 0,  1, 20, 0, 0,  0,  0,  0, 3, 63, 0, 8, 8, 1)); // v14 wrap
    vecs.push_back(mk(1, 1, 0,  1, 20, 0, 0,  0,  0,  0, 1,  1, 2, 8, 8, 1)); // v15
    vecs.push_back(mk(1, 1, 0,  1, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v16 2 > 1
    vecs.push_back(mk(1, 0, 1,  1,  7, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v17 store 8 > 7
    vecs.push_back(mk(1, 0, 1,  1,  8, 0, 0,  0,  0,  0, 1,  2, 2, 8, 9, 1)); // v18 store equality
    vecs.push_back(mk(3, 3, 0, 20, 20, 1, 1, 12,  4,  1, 0,  0, 0, 0, 0, 0)); // v19 branch + dispatch
    vecs.push_back(mk(3, 1, 2, 20, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v20 recover
    vecs.push_back(mk(3, 1, 2, 20, 20, 0, 0,  0,  0,  0, 3, 12,13, 4, 4, 1)); // v21
    vecs.push_back(mk(0, 0, 0, 20, 20, 1, 0, 40, 40,  1, 0,  0, 0, 0, 0, 0)); // v22 no-flush branch
    vecs.push_back(mk(0, 0, 0, 20, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v23 recover
    vecs.push_back(mk(3, 3, 0, 20, 20, 0, 0,  0,  0,  0, 3, 13,14, 5, 5, 1)); // v24 resumes
    vecs.push_back(mk(0, 0, 0, 20, 20, 1, 0, 50, 50,  1, 0,  0, 0, 0, 0, 0)); // v25 branch
    vecs.push_back(mk(0, 0, 0, 20, 20, 1, 0, 50, 50,  1, 0,  0, 0, 0, 0, 0)); // v26 branch in RECOVER
    vecs.push_back(mk(3, 3, 0, 20, 20, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0)); // v27 recover
    vecs.push_back(mk(3, 3, 0, 20, 20, 0, 0,  0,  0,  0, 3, 15,16, 5, 5, 1)); // v28
    vecs.push_back(mk(3, 3, 0, 20, 20, 1, 1, 30, 30,  1, 0,  0, 0, 0, 0, 0)); // v29 flush, enter RECOVER

    // Reset
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset stall", 32'(OUT_stall), 32'd1);
    @(posedge clk);
    #1;
    check("reset out_valid", 32'(OUT_valid), 32'd0);
    check("reset loadSqN", 32'(OUT_loadSqN), 32'd0);
    check("reset storeSqN", 32'(OUT_storeSqN), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset while sitting in RECOVER with dispatch pending
    rst = 1'b1;
    drive(mk(3, 3, 0, 20, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("midrst stall", 32'(OUT_stall), 32'd1);
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(OUT_valid), 32'd0);
    check("midrst loadSqN", 32'(OUT_loadSqN), 32'd0);
    check("midrst storeSqN", 32'(OUT_storeSqN), 32'd0);
    rst = 1'b0;
    #1;
    check("postrst init stall", 32'(OUT_stall), 32'd1);
    @(posedge clk);
    #1;
    check("postrst init out_valid", 32'(OUT_valid), 32'd0);
    check("postrst run stall", 32'(OUT_stall), 32'd0);
    @(posedge clk);
    #1;
    check("postrst out_valid", 32'(OUT_valid), 32'd3);
    check("postrst ld0", 32'(OUT_loadSqN[5:0]), 32'd0);
    check("postrst ld1", 32'(OUT_loadSqN[11:6]), 32'd1);
    check("postrst st0", 32'(OUT_storeSqN[5:0]), 32'd0);
    check("postrst st1", 32'(OUT_storeSqN[11:6]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_sqn_allocator
